// File: rtl/gpr_bank_decode.sv
// gpr_bank_decode: 16-entry general-purpose register bank driven by one-hot
// Rin/Rout select vectors. Each select vector is turned back into an index
// with an OR-encoder, and a separate multi-hot check decides whether the
// select is usable. Malformed selects are ignored and recorded in sticky flags.
//
// Optional feature: define GPR_TRACE_EN to add a registered write-trace port
// (trace_valid / trace_data) that reports each completed write.
//
// Interface timing: writes take effect on the rising clock edge when Rin is
// exactly one-hot. Reads are combinational from Rout, with no bypass from a
// write in the same cycle.
module gpr_bank_decode #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [NREGS-1:0] Rin,
    input  logic [NREGS-1:0] Rout,
    input  logic             BAout,
    output logic [WIDTH-1:0] bus_out,
    output logic             rd_active,
    output logic [IDXW-1:0]  rd_idx,
    output logic [IDXW-1:0]  last_wr_idx,
    output logic [15:0]      wr_count,
`ifdef GPR_TRACE_EN
    output logic             trace_valid,
    output logic [23:0]      trace_data,
`endif
    output logic [1:0]       onehot_err
);

    // OR of the indices of every set bit. This is meaningful only when the
    // vector is one-hot; no priority between set bits is implied.
    function automatic logic [IDXW-1:0] or_encode(input logic [NREGS-1:0] v);
        logic [IDXW-1:0] e;
        e = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (v[k]) e = e | IDXW'(k);
        end
        return e;
    endfunction

    // True when two or more bits of the vector are set.
    function automatic logic is_multi_hot(input logic [NREGS-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            if (v[k] && seen) multi = 1'b1;
            if (v[k]) seen = 1'b1;
        end
        return multi;
    endfunction

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [IDXW-1:0]  last_wr_idx_q, last_wr_idx_d;
    logic [15:0]      wr_count_q, wr_count_d;
    logic [1:0]       onehot_err_q, onehot_err_d;

    logic             rin_multi, rout_multi;
    logic             wr_en;
    logic [IDXW-1:0]  wr_idx;
    logic [IDXW-1:0]  rout_enc;

`ifdef GPR_TRACE_EN
    logic             trace_valid_q, trace_valid_d;
    logic [23:0]      trace_data_q, trace_data_d;
`endif

    // Decode both select vectors into an index plus a validity qualifier.
    always_comb begin
        rin_multi  = is_multi_hot(Rin);
        rout_multi = is_multi_hot(Rout);
        wr_idx     = or_encode(Rin);
        rout_enc   = or_encode(Rout);
        wr_en      = (|Rin) && !rin_multi;
    end

    // Combinational read port. R0 reads as zero when BAout is asserted.
    always_comb begin
        rd_active = (|Rout) && !rout_multi;
        rd_idx    = '0;
        bus_out   = '0;
        if (rd_active) begin
            rd_idx = rout_enc;
            if (!(BAout && (rout_enc == '0))) begin
                bus_out = regs_q[rout_enc];
            end
        end
    end

    // Next-state logic: register write, write bookkeeping and sticky error flags.
    always_comb begin
        regs_d        = regs_q;
        last_wr_idx_d = last_wr_idx_q;
        wr_count_d    = wr_count_q;
        onehot_err_d  = onehot_err_q;
        if (wr_en) begin
            regs_d[wr_idx] = bus_in;
            last_wr_idx_d  = wr_idx;
            wr_count_d     = wr_count_q + 16'd1;
        end
        if (rin_multi)  onehot_err_d[0] = 1'b1;
        if (rout_multi) onehot_err_d[1] = 1'b1;
    end

    // State registers; the asynchronous clear discards any in-flight write.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
            last_wr_idx_q <= '0;
            wr_count_q    <= '0;
            onehot_err_q  <= 2'b00;
        end else begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
            last_wr_idx_q <= last_wr_idx_d;
            wr_count_q    <= wr_count_d;
            onehot_err_q  <= onehot_err_d;
        end
    end

    assign last_wr_idx = last_wr_idx_q;
    assign wr_count    = wr_count_q;
    assign onehot_err  = onehot_err_q;

`ifdef GPR_TRACE_EN
    // Trace record of the write completing at this edge; valid for one cycle.
    always_comb begin
        trace_valid_d = wr_en;
        trace_data_d  = trace_data_q;
        if (wr_en) begin
            trace_data_d = {wr_idx[3:0], 4'b0000, bus_in[15:0]};
        end
    end

    // Trace output registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            trace_valid_q <= 1'b0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_data_q  <= trace_data_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_data  = trace_data_q;
`endif

endmodule

// File: tb/tb_gpr_bank_decode.sv
// Directed self-checking bench for gpr_bank_decode.
module tb_gpr_bank_decode;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        BAout;
    logic [31:0] bus_out;
    logic        rd_active;
    logic [3:0]  rd_idx;
    logic [3:0]  last_wr_idx;
    logic [15:0] wr_count;
    logic [1:0]  onehot_err;
`ifdef GPR_TRACE_EN
    logic        trace_valid;
    logic [23:0] trace_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    gpr_bank_decode dut (
        .clock       (clock),
        .clear       (clear),
        .bus_in      (bus_in),
        .Rin         (Rin),
        .Rout        (Rout),
        .BAout       (BAout),
        .bus_out     (bus_out),
        .rd_active   (rd_active),
        .rd_idx      (rd_idx),
        .last_wr_idx (last_wr_idx),
        .wr_count    (wr_count),
`ifdef GPR_TRACE_EN
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
`endif
        .onehot_err  (onehot_err)
    );

    // Clock: 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear  = 1'b0;
        Rin    = 16'h0004;
        Rout   = 16'h0004;
        bus_in = 32'hA5A5A5A5;
        BAout  = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus_out: got %h expected %h", bus_out, 32'h0);
        end
        n_checks++;
        if (wr_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_wr_count: got %h expected %h", wr_count, 16'h0);
        end
        n_checks++;
        if (onehot_err !== 2'b00) begin
            n_fail++; $display("FAIL reset_onehot_err: got %b expected %b", onehot_err, 2'b00);
        end
        n_checks++;
        if (last_wr_idx !== 4'd0) begin
            n_fail++; $display("FAIL reset_last_wr_idx: got %0d expected %0d", last_wr_idx, 0);
        end
`ifdef GPR_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b0 || trace_data !== 24'h0) begin
            n_fail++; $display("FAIL reset_trace: got %b/%h expected 0/000000", trace_valid, trace_data);
        end
`endif
        Rin   = 16'h0000;
        clear = 1'b1;
        Rout  = 16'h0008;
        #1;
        n_checks++;
        if (bus_out !== 32'h0 || rd_idx !== 4'd3 || rd_active !== 1'b1) begin
            n_fail++; $display("FAIL reset_read_r3: got %h/%0d/%b expected 00000000/3/1", bus_out, rd_idx, rd_active);
        end
        Rout = 16'h0000;
        tick();
    endtask

    task automatic test_write_read();
        Rin    = 16'h0020;
        bus_in = 32'hDEADBEEF;
        tick();
        Rin = 16'h0000;
        n_checks++;
        if (last_wr_idx !== 4'd5 || wr_count !== 16'd1) begin
            n_fail++; $display("FAIL write_r5_status: got %0d/%0d expected 5/1", last_wr_idx, wr_count);
        end
`ifdef GPR_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b1 || trace_data !== 24'h50BEEF) begin
            n_fail++; $display("FAIL trace_write_r5: got %b/%h expected 1/50beef", trace_valid, trace_data);
        end
`endif
        Rout = 16'h0020;
        #1;
        n_checks++;
        if (bus_out !== 32'hDEADBEEF || rd_active !== 1'b1 || rd_idx !== 4'd5) begin
            n_fail++; $display("FAIL read_r5: got %h/%b/%0d expected deadbeef/1/5", bus_out, rd_active, rd_idx);
        end
        tick();
`ifdef GPR_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b0) begin
            n_fail++; $display("FAIL trace_single_pulse: got %b expected 0", trace_valid);
        end
`endif
        Rout = 16'h0000;
        #1;
        n_checks++;
        if (bus_out !== 32'h0 || rd_active !== 1'b0 || rd_idx !== 4'd0) begin
            n_fail++; $display("FAIL read_none: got %h/%b/%0d expected 00000000/0/0", bus_out, rd_active, rd_idx);
        end
    endtask

    task automatic test_baout();
        Rin    = 16'h0001;
        bus_in = 32'h00001234;
        tick();
        Rin   = 16'h0000;
        Rout  = 16'h0001;
        BAout = 1'b1;
        #1;
        n_checks++;
        if (bus_out !== 32'h0 || rd_active !== 1'b1 || rd_idx !== 4'd0) begin
            n_fail++; $display("FAIL baout_r0_forced: got %h/%b/%0d expected 00000000/1/0", bus_out, rd_active, rd_idx);
        end
        BAout = 1'b0;
        #1;
        n_checks++;
        if (bus_out !== 32'h00001234) begin
            n_fail++; $display("FAIL baout_off_r0: got %h expected %h", bus_out, 32'h00001234);
        end
        // BAout has no effect on a non-zero register.
        BAout = 1'b1;
        Rout  = 16'h0020;
        #1;
        n_checks++;
        if (bus_out !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL baout_r5: got %h expected %h", bus_out, 32'hDEADBEEF);
        end
        BAout = 1'b0;
        Rout  = 16'h0000;
    endtask

    task automatic test_same_reg();
        Rin    = 16'h0080;
        bus_in = 32'h00000001;
        tick();
        Rout   = 16'h0080;
        bus_in = 32'h00000002;
        #1;
        n_checks++;
        if (bus_out !== 32'h00000001) begin
            n_fail++; $display("FAIL same_reg_before_edge: got %h expected %h", bus_out, 32'h1);
        end
        tick();
        Rin = 16'h0000;
        #1;
        n_checks++;
        if (bus_out !== 32'h00000002 || wr_count !== 16'd4 || last_wr_idx !== 4'd7) begin
            n_fail++; $display("FAIL same_reg_after_edge: got %h/%0d/%0d expected 00000002/4/7", bus_out, wr_count, last_wr_idx);
        end
        Rout = 16'h0000;
    endtask

    task automatic test_multi_hot();
        Rin    = 16'h0011;
        bus_in = 32'h0000FFFF;
        tick();
        Rin = 16'h0000;
        n_checks++;
        if (wr_count !== 16'd4 || last_wr_idx !== 4'd7 || onehot_err !== 2'b01) begin
            n_fail++; $display("FAIL multi_rin_status: got %0d/%0d/%b expected 4/7/01", wr_count, last_wr_idx, onehot_err);
        end
`ifdef GPR_TRACE_EN
        n_checks++;
        if (trace_valid !== 1'b0) begin
            n_fail++; $display("FAIL multi_rin_trace: got %b expected 0", trace_valid);
        end
`endif
        Rout = 16'h0001;
        #1;
        n_checks++;
        if (bus_out !== 32'h00001234) begin
            n_fail++; $display("FAIL multi_rin_r0_kept: got %h expected %h", bus_out, 32'h00001234);
        end
        Rout = 16'h0010;
        #1;
        n_checks++;
        if (bus_out !== 32'h0) begin
            n_fail++; $display("FAIL multi_rin_r4_kept: got %h expected %h", bus_out, 32'h0);
        end
        Rout = 16'h0300;
        #1;
        n_checks++;
        if (bus_out !== 32'h0 || rd_active !== 1'b0 || rd_idx !== 4'd0 || onehot_err !== 2'b01) begin
            n_fail++; $display("FAIL multi_rout_comb: got %h/%b/%0d/%b expected 00000000/0/0/01", bus_out, rd_active, rd_idx, onehot_err);
        end
        tick();
        n_checks++;
        if (onehot_err !== 2'b11) begin
            n_fail++; $display("FAIL multi_rout_sticky: got %b expected %b", onehot_err, 2'b11);
        end
        Rout   = 16'h0000;
        Rin    = 16'h0002;
        bus_in = 32'h00000055;
        tick();
        Rin = 16'h0000;
        tick();
        n_checks++;
        if (onehot_err !== 2'b11 || wr_count !== 16'd5 || last_wr_idx !== 4'd1) begin
            n_fail++; $display("FAIL err_stays_set: got %b/%0d/%0d expected 11/5/1", onehot_err, wr_count, last_wr_idx);
        end
    endtask

    task automatic test_reset_mid_write();
        Rin    = 16'h0040;
        bus_in = 32'h0BADF00D;
        #3;
        clear = 1'b0;
        #1;
        Rout = 16'h0002;
        #1;
        n_checks++;
        if (bus_out !== 32'h0 || wr_count !== 16'd0 || onehot_err !== 2'b00 || last_wr_idx !== 4'd0) begin
            n_fail++; $display("FAIL mid_write_reset: got %h/%0d/%b/%0d expected 00000000/0/00/0", bus_out, wr_count, onehot_err, last_wr_idx);
        end
        tick();
        Rin   = 16'h0000;
        clear = 1'b1;
        Rout  = 16'h0040;
        #1;
        n_checks++;
        if (bus_out !== 32'h0 || wr_count !== 16'd0) begin
            n_fail++; $display("FAIL mid_write_discarded: got %h/%0d expected 00000000/0", bus_out, wr_count);
        end
        Rout = 16'h0000;
        tick();
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        Rin    = 16'h0008;
        for (int i = 0; i < 65535; i++) begin
            bus_in = $urandom_range(0, 32'hFFFF);
            tick();
`ifdef GPR_TRACE_EN
            if (trace_valid === 1'b1) pulses++;
`endif
        end
        n_checks++;
        if (wr_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_max: got %h expected %h", wr_count, 16'hFFFF);
        end
        bus_in = 32'h0000C0DE;
        tick();
`ifdef GPR_TRACE_EN
        if (trace_valid === 1'b1) pulses++;
        n_checks++;
        if (trace_data !== 24'h30C0DE) begin
            n_fail++; $display("FAIL wrap_trace_data: got %h expected %h", trace_data, 24'h30C0DE);
        end
`endif
        Rin = 16'h0000;
        n_checks++;
        if (wr_count !== 16'h0000 || last_wr_idx !== 4'd3) begin
            n_fail++; $display("FAIL wrap_zero: got %h/%0d expected 0000/3", wr_count, last_wr_idx);
        end
        tick();
        n_checks++;
        if (wr_count !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_hold: got %h expected %h", wr_count, 16'h0000);
        end
`ifdef GPR_TRACE_EN
        n_checks++;
        if (pulses !== 65536 || trace_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_trace_pulses: got %0d/%b expected 65536/0", pulses, trace_valid);
        end
`endif
    endtask

    initial begin
        clear  = 1'b0;
        bus_in = '0;
        Rin    = '0;
        Rout   = '0;
        BAout  = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_baout();
        test_same_reg();
        test_multi_hot();
        test_reset_mid_write();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
